// File: rtl/cpu_rp2a03_apu_frame_sequencer.sv
// APU frame sequencer with the $4015 status/enable and $4017 mode/IRQ-inhibit registers.
// Optional macro APU_FRAME_IRQ_EN enables the frame IRQ flag.
module cpu_rp2a03_apu_frame_sequencer #(
  parameter int CNT_W    = 16,
  parameter int STEP1    = 7457,
  parameter int STEP2    = 14913,
  parameter int STEP3    = 22371,
  parameter int STEP4_M0 = 29829,
  parameter int STEP4_M1 = 37281
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cpu_cycle_i,
  input  logic       status_reg_wr_i,
  input  logic       frame_reg_wr_i,
  input  logic       status_reg_rd_i,
  input  logic [7:0] regs_wr_data_i,
  output logic [7:0] status_rd_data_o,
  input  logic [4:0] channel_is_active_i,
  input  logic       dmc_irq_i,
  output logic [4:0] channel_enabled_o,
  output logic       quarter_frame_o,
  output logic       half_frame_o,
  output logic       irq_o
);

  localparam logic [CNT_W-1:0] S1   = CNT_W'(STEP1);
  localparam logic [CNT_W-1:0] S2   = CNT_W'(STEP2);
  localparam logic [CNT_W-1:0] S3   = CNT_W'(STEP3);
  localparam logic [CNT_W-1:0] S4M0 = CNT_W'(STEP4_M0);
  localparam logic [CNT_W-1:0] S4M1 = CNT_W'(STEP4_M1);
  localparam logic [CNT_W-1:0] S4PR = CNT_W'(STEP4_M0 - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             inhibit_q, inhibit_d;
  logic             parity_q, parity_d;
  logic [2:0]       delay_q, delay_d;
  logic [4:0]       en_q, en_d;
  logic             qf_q, qf_d;
  logic             hf_q, hf_d;
  logic [7:0]       rd_q, rd_d;
  logic [CNT_W-1:0] final_w;
  logic             irq_bit_w;
  logic             unused_ok;

  assign final_w = mode_q ? S4M1 : S4M0;

  always_comb begin
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    inhibit_d = inhibit_q;
    parity_d  = parity_q;
    delay_d   = delay_q;
    en_d      = en_q;
    qf_d      = 1'b0;
    hf_d      = 1'b0;
    rd_d      = rd_q;
    if (cpu_cycle_i) begin
      parity_d = ~parity_q;
      cnt_d    = (cnt_q == final_w) ? '0 : cnt_q + CNT_W'(1);
      if (cnt_q == S1 || cnt_q == S2 || cnt_q == S3 || cnt_q == final_w)
        qf_d = 1'b1;
      if (cnt_q == S2 || cnt_q == final_w)
        hf_d = 1'b1;
      // Pending $4017 restart: the matched step strobe still fires
      if (delay_q != 3'd0) begin
        delay_d = delay_q - 3'd1;
        if (delay_q == 3'd1) begin
          cnt_d = '0;
          if (mode_q) begin
            qf_d = 1'b1;
            hf_d = 1'b1;
          end
        end
      end
    end
    if (frame_reg_wr_i) begin
      mode_d    = regs_wr_data_i[7];
      inhibit_d = regs_wr_data_i[6];
      delay_d   = parity_q ? 3'd4 : 3'd3;
    end
    if (status_reg_wr_i)
      en_d = regs_wr_data_i[4:0];
    if (status_reg_rd_i)
      rd_d = {dmc_irq_i, irq_bit_w, 1'b0, channel_is_active_i};
  end

`ifdef APU_FRAME_IRQ_EN
  logic irq_flag_q, irq_flag_d;

  always_comb begin
    irq_flag_d = irq_flag_q;
    if (status_reg_rd_i)
      irq_flag_d = 1'b0;
    if (cpu_cycle_i && !mode_q && !inhibit_q &&
        (cnt_q == S4PR || cnt_q == S4M0))
      irq_flag_d = 1'b1;
    if (frame_reg_wr_i && regs_wr_data_i[6])
      irq_flag_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) irq_flag_q <= 1'b0;
    else       irq_flag_q <= irq_flag_d;
  end

  assign irq_bit_w = irq_flag_q;
  assign irq_o     = irq_flag_q | dmc_irq_i;
`else
  assign irq_bit_w = 1'b0;
  assign irq_o     = dmc_irq_i;
`endif

  assign unused_ok = ^{regs_wr_data_i[5], inhibit_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      inhibit_q <= 1'b0;
      parity_q  <= 1'b0;
      delay_q   <= 3'd0;
      en_q      <= 5'd0;
      qf_q      <= 1'b0;
      hf_q      <= 1'b0;
      rd_q      <= 8'd0;
    end else begin
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      inhibit_q <= inhibit_d;
      parity_q  <= parity_d;
      delay_q   <= delay_d;
      en_q      <= en_d;
      qf_q      <= qf_d;
      hf_q      <= hf_d;
      rd_q      <= rd_d;
    end
  end

  assign channel_enabled_o = en_q;
  assign quarter_frame_o   = qf_q;
  assign half_frame_o      = hf_q;
  assign status_rd_data_o  = rd_q;

endmodule
